// File: rtl/sprint1_video_capture.sv
// SPRINT1 video capture: samples mono video on ce_pix, emits ARGB8888 pixels with x/y tags,
// line/frame strobes, measured active geometry and a lock flag.
// Latency 1 clk from the sampling ce_pix cycle; no backpressure (display side must accept every pixel).
// Optional scanline dimming of odd lines: define VIDCAP_SCANLINE_EN.
module sprint1_video_capture #(
  parameter int          XW     = 9,
  parameter int          YW     = 9,
  parameter logic [23:0] BG_RGB = 24'h808080
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          video_w,
  input  logic          video_b,
  input  logic          hblank,
  input  logic          vblank,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [31:0]   pix_argb,
  output logic          line_start,
  output logic          frame_start,
  output logic [XW-1:0] frame_width,
  output logic [YW-1:0] frame_height,
  output logic          locked,
  output logic          overflow
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

  lock_state_t   state_q, state_d;
  logic [XW-1:0] x_cnt;
  logic [XW-1:0] max_w;
  logic [YW-1:0] y_cnt;
  logic          hblank_q, vblank_q;
  logic          line_has_px;
  logic          frame_has_px;

  logic          active;
  logic          x_full, y_full;
  logic [XW-1:0] x_len;
  logic [YW-1:0] y_after;
  logic          hb_rise, vb_rise, vb_fall;
  logic          line_end;
  logic          x_ovf, y_ovf;
  logic          capture;
  logic          ovf_at_cap;
  logic          geom_equal;
  logic [23:0]   rgb;

  // Sample-level decode: blanking edges, saturation and the line length including this pixel.
  always_comb begin
    active     = ~hblank & ~vblank;
    x_full     = &x_cnt;
    y_full     = &y_cnt;
    x_len      = x_full ? x_cnt : x_cnt + X_ONE;
    hb_rise    = hblank & ~hblank_q;
    vb_rise    = vblank & ~vblank_q;
    vb_fall    = ~vblank & vblank_q;
    line_end   = hb_rise & line_has_px;
    x_ovf      = active & x_full;
    y_ovf      = line_end & y_full;
    // A line closing on the same sample as vblank rising still counts toward the height.
    y_after    = (line_end && !y_full) ? y_cnt + Y_ONE : y_cnt;
    capture    = ce_pix & vb_rise & frame_has_px;
    ovf_at_cap = overflow | x_ovf | y_ovf;
    geom_equal = (max_w == frame_width) && (y_after == frame_height);
  end

  // Colour map: black has priority over white; neither selects the background colour.
  always_comb begin
    rgb = BG_RGB;
    if (video_b) begin
      rgb = 24'h000000;
    end else if (video_w) begin
      rgb = 24'hFFFFFF;
    end
`ifdef VIDCAP_SCANLINE_EN
    if (y_cnt[0]) begin
      rgb = {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
    end
`else
`endif
  end

  // Lock state machine: advances on equal consecutive captures, falls back on any change or overflow.
  always_comb begin
    state_d = state_q;
    if (capture) begin
      if (ovf_at_cap || !geom_equal) begin
        state_d = UNLOCKED;
      end else begin
        case (state_q)
          UNLOCKED: state_d = CHECK;
          CHECK:    state_d = LOCKED;
          LOCKED:   state_d = LOCKED;
          default:  state_d = UNLOCKED;
        endcase
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  assign locked = (state_q == LOCKED);

  // Raster tracking: blank edge history, x/y counters and per-line/per-frame activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      max_w        <= '0;
      line_has_px  <= 1'b0;
      frame_has_px <= 1'b0;
    end else if (ce_pix) begin
      hblank_q <= hblank;
      vblank_q <= vblank;

      if (hblank) begin
        x_cnt <= '0;
      end else if (active && !x_full) begin
        x_cnt <= x_cnt + X_ONE;
      end

      if (vblank) begin
        y_cnt <= '0;
      end else if (line_end && !y_full) begin
        y_cnt <= y_cnt + Y_ONE;
      end

      if (active) begin
        line_has_px <= 1'b1;
      end else begin
        line_has_px <= 1'b0;
      end

      if (active) begin
        frame_has_px <= 1'b1;
      end else if (vblank) begin
        frame_has_px <= 1'b0;
      end

      // Longest line of the frame; read at the capture sample before it clears.
      if (vblank) begin
        max_w <= '0;
      end else if (active && (x_len > max_w)) begin
        max_w <= x_len;
      end
    end
  end

  // Geometry capture at the end of each frame that had active lines; overflow is sticky per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_width  <= '0;
      frame_height <= '0;
      overflow     <= 1'b0;
    end else if (ce_pix) begin
      if (capture) begin
        frame_width  <= max_w;
        frame_height <= y_after;
      end
      if (vb_fall) begin
        overflow <= 1'b0;
      end
      if (x_ovf || y_ovf) begin
        overflow <= 1'b1;
      end
    end
  end

  // Pixel outputs: strobes last one clk, tag/colour hold until the next enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_argb    <= 32'h0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        pix_valid   <= active;
        line_start  <= active && (x_cnt == '0);
        frame_start <= active && (x_cnt == '0) && (y_cnt == '0);
        if (active) begin
          pix_x    <= x_cnt;
          pix_y    <= y_cnt;
          pix_argb <= {8'hFF, rgb};
        end else begin
          pix_argb <= 32'h0;
        end
      end
    end
  end

endmodule
